// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku game controller slice.
//   state_t       : 4-bit game state encoding, exposed on the controller's state port
//   *_DEF         : default board side, difficulty width and mistake counter width
package sudoku_pkg;

  localparam int unsigned N_DEF      = 9;
  localparam int unsigned DIFF_W_DEF = 2;
  localparam int unsigned MIST_W_DEF = 2;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_PLAY  = 4'd2,
    ST_CHECK = 4'd3,
    ST_WAIT  = 4'd4,
    ST_WON   = 4'd5,
    ST_LOST  = 4'd6
  } state_t;

endpackage

// File: rtl/sudoku_check_seq.sv
// Row sweep sequencer for the solution check.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_ridx_clr/inc  : clear / advance the row index (advance stops at N-1)
//   i_tmo_clr/inc   : clear / advance the datapath wait counter
//   o_ridx          : row currently under check
//   o_tmo_expired   : high during the DP_TIMEOUT-th wait cycle
module sudoku_check_seq #(
  parameter int unsigned N          = 9,
  parameter int unsigned DP_TIMEOUT = 15,
  localparam int unsigned RIDX_W    = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned TMO_W     = $clog2(DP_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ridx_clr,
  input  logic              i_ridx_inc,
  input  logic              i_tmo_clr,
  input  logic              i_tmo_inc,
  output logic [RIDX_W-1:0] o_ridx,
  output logic              o_tmo_expired
);

  logic [RIDX_W-1:0] r_ridx;
  logic [TMO_W-1:0]  r_tmo;
  logic              w_ridx_last;

  assign w_ridx_last   = (r_ridx == RIDX_W'(N - 1));
  // Counter holds k-1 during wait cycle k, so expiry lands on cycle DP_TIMEOUT.
  assign o_tmo_expired = (r_tmo == TMO_W'(DP_TIMEOUT - 1));
  assign o_ridx        = r_ridx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ridx <= '0;
    end else if (i_ridx_clr) begin
      r_ridx <= '0;
    end else if (i_ridx_inc && !w_ridx_last) begin
      r_ridx <= r_ridx + RIDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (i_tmo_clr) begin
      r_tmo <= '0;
    end else if (i_tmo_inc && !o_tmo_expired) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

endmodule

// File: rtl/sudoku_game_ctrl.sv
// Sudoku game controller: puzzle load, play, row-by-row solution check,
// mistake limiting, saturating move counter and datapath timeout.
//   clka, restart_n         : clock, asynchronous active-low reset
//   restart                 : synchronous game restart (highest priority)
//   enter                   : start / commit strobe
//   difficulty -> diff_q    : latched when leaving IDLE
//   load_done / load_req    : puzzle load handshake
//   dp_check, ridx          : row-check request and row index
//   dp_valid, dp_ok         : row-check result
//   state, mistakes, moves  : status
//   won, lost               : terminal state flags
module sudoku_game_ctrl
  import sudoku_pkg::*;
#(
  parameter int unsigned N            = N_DEF,
  parameter int unsigned DIFF_W       = DIFF_W_DEF,
  parameter int unsigned MAX_MISTAKES = 3,
  parameter int unsigned MIST_W       = MIST_W_DEF,
  parameter int unsigned MOVE_W       = 8,
  parameter int unsigned DP_TIMEOUT   = 15,
  localparam int unsigned RIDX_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clka,
  input  logic              restart_n,
  input  logic              restart,
  input  logic              enter,
  input  logic [DIFF_W-1:0] difficulty,
  input  logic              load_done,
  input  logic              dp_valid,
  input  logic              dp_ok,
  output logic              load_req,
  output logic [DIFF_W-1:0] diff_q,
  output logic              dp_check,
  output logic [RIDX_W-1:0] ridx,
  output logic [3:0]        state,
  output logic [MIST_W-1:0] mistakes,
  output logic [MOVE_W-1:0] moves,
  output logic              won,
  output logic              lost
);

  state_t            r_state, w_state_nx;
  logic [DIFF_W-1:0] r_diff;
  logic [MIST_W-1:0] r_mistakes, w_mist_plus;
  logic [MOVE_W-1:0] r_moves;
  logic              w_ridx_clr, w_ridx_inc, w_tmo_clr, w_tmo_inc, w_tmo_expired;
  logic              w_mist_clr, w_mist_inc, w_moves_clr, w_moves_inc, w_latch_diff;
  logic [RIDX_W-1:0] w_ridx;

  sudoku_check_seq #(
    .N          (N),
    .DP_TIMEOUT (DP_TIMEOUT)
  ) u_check_seq (
    .clk           (clka),
    .rst_n         (restart_n),
    .i_ridx_clr    (w_ridx_clr),
    .i_ridx_inc    (w_ridx_inc),
    .i_tmo_clr     (w_tmo_clr),
    .i_tmo_inc     (w_tmo_inc),
    .o_ridx        (w_ridx),
    .o_tmo_expired (w_tmo_expired)
  );

  assign w_mist_plus = r_mistakes + MIST_W'(1);

  always_comb begin
    w_state_nx   = r_state;
    w_ridx_clr   = 1'b0;
    w_ridx_inc   = 1'b0;
    w_tmo_clr    = 1'b0;
    w_tmo_inc    = 1'b0;
    w_mist_clr   = 1'b0;
    w_mist_inc   = 1'b0;
    w_moves_clr  = 1'b0;
    w_moves_inc  = 1'b0;
    w_latch_diff = 1'b0;
    if (restart) begin
      w_state_nx  = ST_IDLE;
      w_ridx_clr  = 1'b1;
      w_tmo_clr   = 1'b1;
      w_mist_clr  = 1'b1;
      w_moves_clr = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: if (enter) begin
          w_state_nx   = ST_LOAD;
          w_latch_diff = 1'b1;
          w_mist_clr   = 1'b1;
          w_moves_clr  = 1'b1;
          w_ridx_clr   = 1'b1;
        end
        ST_LOAD: if (load_done) w_state_nx = ST_PLAY;
        ST_PLAY: if (enter) begin
          w_state_nx  = ST_CHECK;
          w_moves_inc = 1'b1;
          w_ridx_clr  = 1'b1;
        end
        ST_CHECK: begin
          w_state_nx = ST_WAIT;
          w_tmo_clr  = 1'b1;
        end
        ST_WAIT: begin
          // A result arriving on the expiry cycle takes precedence over the timeout.
          if (dp_valid && dp_ok) begin
            if (w_ridx == RIDX_W'(N - 1)) begin
              w_state_nx = ST_WON;
            end else begin
              w_ridx_inc = 1'b1;
              w_state_nx = ST_CHECK;
            end
          end else if (dp_valid || w_tmo_expired) begin
            w_mist_inc = 1'b1;
            w_state_nx = (w_mist_plus == MIST_W'(MAX_MISTAKES)) ? ST_LOST : ST_PLAY;
          end else begin
            w_tmo_inc = 1'b1;
          end
        end
        ST_WON, ST_LOST: if (enter) w_state_nx = ST_IDLE;
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nx;
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      r_diff     <= '0;
      r_mistakes <= '0;
      r_moves    <= '0;
    end else begin
      if (w_latch_diff) r_diff <= difficulty;
      if (w_mist_clr) begin
        r_mistakes <= '0;
      end else if (w_mist_inc && (r_mistakes != MIST_W'(MAX_MISTAKES))) begin
        r_mistakes <= w_mist_plus;
      end
      if (w_moves_clr) begin
        r_moves <= '0;
      end else if (w_moves_inc && (r_moves != '1)) begin
        r_moves <= r_moves + MOVE_W'(1);
      end
    end
  end

  assign state    = r_state;
  assign load_req = (r_state == ST_LOAD);
  assign dp_check = (r_state == ST_CHECK);
  assign won      = (r_state == ST_WON);
  assign lost     = (r_state == ST_LOST);
  assign ridx     = w_ridx;
  assign diff_q   = r_diff;
  assign mistakes = r_mistakes;
  assign moves    = r_moves;

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Directed bench for sudoku_game_ctrl: a default N=9 instance and an N=4
// instance with a large mistake limit, driven from shared inputs.
module tb_sudoku_game_ctrl;

  logic       clka = 1'b0;
  logic       restart_n = 1'b0;
  logic       restart = 1'b0;
  logic       enter = 1'b0;
  logic [1:0] difficulty = 2'd0;
  logic       load_done = 1'b0;
  logic       dp_valid = 1'b0;
  logic       dp_ok = 1'b0;

  logic       load_req, dp_check, won, lost;
  logic [1:0] diff_q;
  logic [3:0] ridx;
  logic [3:0] state;
  logic [1:0] mistakes;
  logic [7:0] moves;

  logic       load_req_4, dp_check_4, won_4, lost_4;
  logic [1:0] diff_q_4;
  logic [1:0] ridx_4;
  logic [3:0] state_4;
  logic [8:0] mistakes_4;
  logic [7:0] moves_4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clka = ~clka;

  sudoku_game_ctrl u_dut (
    .clka(clka), .restart_n(restart_n), .restart(restart), .enter(enter),
    .difficulty(difficulty), .load_done(load_done), .dp_valid(dp_valid), .dp_ok(dp_ok),
    .load_req(load_req), .diff_q(diff_q), .dp_check(dp_check), .ridx(ridx),
    .state(state), .mistakes(mistakes), .moves(moves), .won(won), .lost(lost)
  );

  sudoku_game_ctrl #(
    .N(4), .MIST_W(9), .MAX_MISTAKES(400)
  ) u_dut4 (
    .clka(clka), .restart_n(restart_n), .restart(restart), .enter(enter),
    .difficulty(difficulty), .load_done(load_done), .dp_valid(dp_valid), .dp_ok(dp_ok),
    .load_req(load_req_4), .diff_q(diff_q_4), .dp_check(dp_check_4), .ridx(ridx_4),
    .state(state_4), .mistakes(mistakes_4), .moves(moves_4), .won(won_4), .lost(lost_4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic go_play();
    enter = 1'b1; step(); enter = 1'b0;
    load_done = 1'b1; step(); load_done = 1'b0;
  endtask

  task automatic commit();
    enter = 1'b1; step(); enter = 1'b0;
  endtask

  task automatic pass_row();
    step();
    dp_valid = 1'b1; dp_ok = 1'b1; step();
    dp_valid = 1'b0; dp_ok = 1'b0;
  endtask

  task automatic fail_row();
    step();
    dp_valid = 1'b1; dp_ok = 1'b0; step();
    dp_valid = 1'b0;
  endtask

  initial begin
    step(); step();
    check("rst_state", 32'(state), 0);
    check("rst_ridx", 32'(ridx), 0);
    check("rst_moves", 32'(moves), 0);
    check("rst_diffq", 32'(diff_q), 0);
    check("rst_loadreq", 32'(load_req), 0);
    restart_n = 1'b1;
    step();

    // Full pass on N=9
    enter = 1'b1; step(); enter = 1'b0;
    check("load_state", 32'(state), 1);
    check("load_req", 32'(load_req), 1);
    step();
    check("load_hold", 32'(state), 1);
    load_done = 1'b1; step(); load_done = 1'b0;
    check("play_state", 32'(state), 2);
    commit();
    check("commit_moves", 32'(moves), 1);
    for (int r = 0; r < 9; r++) begin
      check($sformatf("pass_dpcheck%0d", r), 32'(dp_check), 1);
      check($sformatf("pass_ridx%0d", r), 32'(ridx), 32'(r));
      pass_row();
    end
    check("won_state", 32'(state), 5);
    check("won_flag", 32'(won), 1);
    check("won_moves", 32'(moves), 1);
    check("won_ridx", 32'(ridx), 8);
    enter = 1'b1; step(); enter = 1'b0;
    check("won_to_idle", 32'(state), 0);

    // Three failures at row 4
    go_play();
    check("fail_mist_clr", 32'(mistakes), 0);
    for (int k = 1; k <= 3; k++) begin
      commit();
      for (int r = 0; r < 4; r++) pass_row();
      check($sformatf("fail%0d_ridx", k), 32'(ridx), 4);
      fail_row();
      check($sformatf("fail%0d_mist", k), 32'(mistakes), 32'(k));
      check($sformatf("fail%0d_state", k), 32'(state), (k < 3) ? 2 : 6);
    end
    check("lost_flag", 32'(lost), 1);
    enter = 1'b1; step(); enter = 1'b0;
    check("lost_to_idle", 32'(state), 0);

    // Asynchronous reset in WAIT
    go_play();
    commit(); pass_row(); fail_row();
    commit(); pass_row(); step();
    check("pre_rst_state", 32'(state), 4);
    check("pre_rst_ridx", 32'(ridx), 1);
    check("pre_rst_mist", 32'(mistakes), 1);
    restart_n = 1'b0;
    #2;
    check("arst_state", 32'(state), 0);
    check("arst_ridx", 32'(ridx), 0);
    check("arst_mist", 32'(mistakes), 0);
    check("arst_dpcheck", 32'(dp_check), 0);
    step();
    restart_n = 1'b1;
    step();

    // Datapath timeout and late-but-valid result
    go_play();
    commit(); step();
    check("tmo_wait", 32'(state), 4);
    repeat (14) step();
    check("tmo_cyc15", 32'(state), 4);
    step();
    check("tmo_state", 32'(state), 2);
    check("tmo_mist", 32'(mistakes), 1);
    commit(); step();
    repeat (14) step();
    dp_valid = 1'b1; dp_ok = 1'b1; step(); dp_valid = 1'b0; dp_ok = 1'b0;
    check("late_ok_state", 32'(state), 3);
    check("late_ok_ridx", 32'(ridx), 1);
    check("late_ok_mist", 32'(mistakes), 1);
    fail_row();
    check("pre_rs_state", 32'(state), 2);
    check("pre_rs_moves", 32'(moves), 2);

    // Synchronous restart beats enter in PLAY
    restart = 1'b1; enter = 1'b1; step(); restart = 1'b0; enter = 1'b0;
    check("rs_state", 32'(state), 0);
    check("rs_moves", 32'(moves), 0);
    check("rs_mist", 32'(mistakes), 0);

    // N=4 sweep with difficulty latch
    difficulty = 2'b10;
    go_play();
    difficulty = 2'b01;
    check("n4_diffq", 32'(diff_q_4), 2);
    check("n4_play", 32'(state_4), 2);
    commit();
    for (int r = 0; r < 4; r++) begin
      check($sformatf("n4_dpcheck%0d", r), 32'(dp_check_4), 1);
      check($sformatf("n4_ridx%0d", r), 32'(ridx_4), 32'(r));
      pass_row();
    end
    check("n4_won", 32'(won_4), 1);
    check("n4_ridx_end", 32'(ridx_4), 3);
    check("n4_diffq_held", 32'(diff_q_4), 2);

    // Move counter saturation on the N=4 instance
    restart = 1'b1; step(); restart = 1'b0;
    go_play();
    for (int c = 0; c < 300; c++) begin
      commit();
      fail_row();
    end
    check("sat_moves", 32'(moves_4), 255);
    check("sat_mist", 32'(mistakes_4), 300);
    check("sat_state", 32'(state_4), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
